// File: rtl/sampler_if.sv
// sampler_if: RX sampler signal bundle.
// master = serial front end / CDR side (drives Serial and phase_sel);
// slave  = the sampler itself (drives the bang-bang triple and flags).
interface sampler_if #(
  parameter int OSR = 4
);
  localparam int PW = $clog2(OSR);

  logic          Serial;
  logic [PW-1:0] phase_sel;
  logic          Dn_1;
  logic          Pn;
  logic          Dn;
  logic          sample_vld;
  logic          early;
  logic          late;

  modport master (
    output Serial,
    output phase_sel,
    input  Dn_1,
    input  Pn,
    input  Dn,
    input  sample_vld,
    input  early,
    input  late
  );

  modport slave (
    input  Serial,
    input  phase_sel,
    output Dn_1,
    output Pn,
    output Dn,
    output sample_vld,
    output early,
    output late
  );
endinterface

// File: rtl/sampler.sv
// sampler: oversampled RX data/edge sampler producing the Alexander
// bang-bang triple (Dn_1, Pn, Dn) plus early/late phase flags.
//
// One UI spans OSR clock cycles (OSR a power of two, >= 4). A free-running
// phase counter selects one data strobe and one edge strobe per UI. The
// "edge where cnt == X" is the rising edge at which cnt takes the value X,
// so the decisions below are made on the counter's next value. The active
// data phase only changes at a UI boundary (the edge leaving cnt == OSR-1),
// so a mid-UI phase_sel change can neither skip nor double a strobe.
//
// Optional feature macro: SAMPLER_SYNC_EN
//   defined     -> Serial passes through a two-flop synchronizer first
//                  (all capture phases see the input 2 cycles later)
//   not defined -> Serial is sampled directly
module sampler #(
  parameter int OSR = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  sampler_if.slave   bus
);
  localparam int          PW   = $clog2(OSR);
  localparam logic [PW-1:0] LAST = PW'(OSR - 1);
  localparam logic [PW-1:0] HALF = PW'(OSR / 2);

  logic [PW-1:0] cnt;
  logic [PW-1:0] ph_q;
  logic [PW-1:0] cnt_next;
  logic [PW-1:0] ph_next;
  logic          data_hit;
  logic          edge_hit;
  logic          s;
  logic          e_q;

  logic          d_prev;
  logic          p_edge;
  logic          d_cur;
  logic          vld;
  logic          early_q;
  logic          late_q;

`ifdef SAMPLER_SYNC_EN
  logic sync_1;
  logic sync_2;

  // Two-flop synchronizer on the raw serial pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= bus.Serial;
      sync_2 <= sync_1;
    end
  end

  assign s = sync_2;
`else
  assign s = bus.Serial;
`endif

  // Next counter / phase values and the strobe decisions derived from them.
  // Edge phase wraps naturally through PW-bit overflow.
  always_comb begin
    cnt_next = cnt + PW'(1);
    ph_next  = ph_q;
    if (cnt == LAST) begin
      ph_next = bus.phase_sel;
    end
    data_hit = (cnt_next == ph_next);
    edge_hit = (cnt_next == (ph_next + HALF));
  end

  // Phase counter and boundary-aligned phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      ph_q <= '0;
    end else begin
      cnt  <= cnt_next;
      ph_q <= ph_next;
    end
  end

  // Mid-UI edge sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= 1'b0;
    end else if (edge_hit) begin
      e_q <= s;
    end
  end

  // Data strobe: shift the triple and decide early/late in one step.
  // A glitch (Dn_1 == Dn, Pn different) leaves both flags low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_prev  <= 1'b0;
      p_edge  <= 1'b0;
      d_cur   <= 1'b0;
      vld     <= 1'b0;
      early_q <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      vld <= data_hit;
      if (data_hit) begin
        d_prev  <= d_cur;
        p_edge  <= e_q;
        d_cur   <= s;
        late_q  <= (d_cur != e_q) && (e_q == s);
        early_q <= (e_q != s) && (d_cur == e_q);
      end
    end
  end

  assign bus.Dn_1       = d_prev;
  assign bus.Pn         = p_edge;
  assign bus.Dn         = d_cur;
  assign bus.sample_vld = vld;
  assign bus.early      = early_q;
  assign bus.late       = late_q;
endmodule

// File: tb/tb_sampler.sv
// tb_sampler: randomized and directed checks of sampler (OSR = 4) against a
// cycle-indexed reference model. Works with or without SAMPLER_SYNC_EN.
`timescale 1ns/1ps
module tb_sampler;
  localparam int OSR = 4;
`ifdef SAMPLER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sampler_if #(.OSR(OSR)) sif ();

  sampler #(.OSR(OSR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  logic [5:0] dut_vec;
  assign dut_vec = {sif.Dn_1, sif.Pn, sif.Dn, sif.sample_vld, sif.early, sif.late};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: k counts clock edges since reset release, so the
  // counter value after edge k is k mod OSR. The triple and flags are
  // derived from the sampled bit history by the bang-bang rules.
  int k;
  int mph;
  bit m_e, m_dn_1, m_pn, m_dn, m_vld, m_early, m_late;
  bit sy1, sy2;

  function automatic logic [5:0] exp_vec();
    return {m_dn_1, m_pn, m_dn, m_vld, m_early, m_late};
  endfunction

  task automatic model_reset();
    k = 0; mph = 0;
    m_e = 0; m_dn_1 = 0; m_pn = 0; m_dn = 0; m_vld = 0; m_early = 0; m_late = 0;
    sy1 = 0; sy2 = 0;
  endtask

  task automatic model_edge();
    int pos;
    bit s_now;
    k   = k + 1;
    pos = k % OSR;
    s_now = (LAT == 2) ? sy2 : sif.Serial;
    if (pos == 0) mph = int'(sif.phase_sel);
    m_vld = 0;
    if (pos == mph) begin
      m_dn_1  = m_dn;
      m_pn    = m_e;
      m_dn    = s_now;
      m_vld   = 1;
      m_late  = (m_dn_1 != m_pn) && (m_pn == m_dn);
      m_early = (m_pn != m_dn) && (m_dn_1 == m_pn);
    end
    if (pos == (mph + OSR / 2) % OSR) m_e = s_now;
    sy2 = sy1;
    sy1 = sif.Serial;
  endtask

  // Advance one clock; outputs are examined 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic align_to(input int pos);
    for (int i = 0; i < OSR && (k % OSR) != pos; i++) tick();
  endtask

  task automatic test_reset();
    int n;
    bit found;
    rst_n = 1'b0;
    model_reset();
    sif.Serial = 1'b0;
    sif.phase_sel = '0;
    for (int i = 0; i < 8; i++) begin
      sif.Serial = 1'($urandom);
      tick();
      checks++;
      if (dut_vec !== 6'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=000000", i, dut_vec);
      end
    end
    sif.Serial = 1'b0;
    rst_n = 1'b1;
    for (int r = 0; r < 3; r++) begin
      n = 0; found = 0;
      for (int i = 1; i <= 12 && !found; i++) begin
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL reset_release got=%b exp=%b", dut_vec, exp_vec());
        end
        if (sif.sample_vld) begin n = i; found = 1; end
      end
      checks++;
      if (n != 4) begin
        errors++;
        $display("FAIL strobe_spacing idx=%0d got=%0d exp=4", r, n);
      end
    end
  endtask

  task automatic test_constant_one();
    sif.Serial = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL const_one got=%b exp=%b", dut_vec, exp_vec());
      end
    end
    align_to(0);
    checks++;
    if (dut_vec !== 6'b111100) begin
      errors++;
      $display("FAIL const_one_triple got=%b exp=111100", dut_vec);
    end
  endtask

  task automatic test_early();
    sif.Serial = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    align_to((6 - LAT) % OSR);
    sif.Serial = 1'b1;
    for (int i = 0; i < 2 + LAT; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL early_model got=%b exp=%b", dut_vec, exp_vec());
      end
    end
    checks++;
    if (dut_vec !== 6'b001110) begin
      errors++;
      $display("FAIL early_triple got=%b exp=001110", dut_vec);
    end
  endtask

  task automatic test_late();
    sif.Serial = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    align_to((5 - LAT) % OSR);
    sif.Serial = 1'b1;
    for (int i = 0; i < 3 + LAT; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL late_model got=%b exp=%b", dut_vec, exp_vec());
      end
    end
    checks++;
    if (dut_vec !== 6'b011101) begin
      errors++;
      $display("FAIL late_triple got=%b exp=011101", dut_vec);
    end
  endtask

  task automatic test_phase_change();
    int n;
    bit found;
    sif.phase_sel = '0;
    for (int i = 0; i < 8; i++) begin sif.Serial = 1'($urandom); tick(); end
    align_to(0);
    sif.Serial = 1'($urandom);
    tick();
    sif.phase_sel = 2'd2;
    for (int r = 0; r < 3; r++) begin
      n = 1; found = 0;
      if (r > 0) n = 0;
      for (int i = 1; i <= 16 && !found; i++) begin
        sif.Serial = 1'($urandom);
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL phase_model got=%b exp=%b", dut_vec, exp_vec());
        end
        if (sif.sample_vld) begin n = n + i; found = 1; end
      end
      checks++;
      if (n != ((r == 0) ? 6 : 4)) begin
        errors++;
        $display("FAIL phase_spacing idx=%0d got=%0d exp=%0d", r, n, (r == 0) ? 6 : 4);
      end
    end
    sif.phase_sel = '0;
    for (int i = 0; i < 8; i++) begin
      sif.Serial = 1'($urandom);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL phase_back got=%b exp=%b", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      sif.Serial = 1'($urandom);
      if ($urandom_range(7) == 0) sif.phase_sel = 2'($urandom);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rand cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      checks++;
      if (sif.early && sif.late) begin
        errors++;
        $display("FAIL rand_flags cyc=%0d got early=1 late=1 exp not both", i);
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    bit found;
    sif.phase_sel = 2'd1;
    for (int i = 0; i < 20; i++) begin sif.Serial = 1'($urandom); tick(); end
    sif.Serial = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 6'b0) begin
      errors++;
      $display("FAIL async_reset got=%b exp=000000", dut_vec);
    end
    tick();
    tick();
    sif.phase_sel = '0;
    rst_n = 1'b1;
    n = 0; found = 0;
    for (int i = 1; i <= 12 && !found; i++) begin
      sif.Serial = 1'($urandom);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL async_restart got=%b exp=%b", dut_vec, exp_vec());
      end
      if (sif.sample_vld) begin n = i; found = 1; end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL async_first_strobe got=%0d exp=4", n);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    sif.Serial = 1'b0;
    sif.phase_sel = '0;
    model_reset();
    test_reset();
    test_constant_one();
    test_early();
    test_late();
    test_phase_change();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
